led_ctrl_multi: RTL and testbench

//  Parametrised multi-channel LED controller; successor to the single-LED driver.
//  NUM_CH independent channels, each runtime-configured to OFF, ON, BLINK or BREATHE (PWM fade).
//  A shared prescaler produces a slow tick that paces BLINK and BREATHE.

---
 rtl/led_pkg.sv | 13 +
 rtl/led_ch.sv | 97 +++++++++
 rtl/led_ctrl_multi.sv | 85 ++++++++
 tb/tb_led_ctrl_multi.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED controller.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF     = 2'd0;
  localparam mode_t MODE_ON      = 2'd1;
  localparam mode_t MODE_BLINK   = 2'd2;
  localparam mode_t MODE_BREATHE = 2'd3;

  localparam int unsigned PWM_W_DEFAULT = 8;

endpackage

// File: rtl/led_ch.sv
// One LED channel: holds its mode/period config and the blink/breathe sequencing state.
module led_ch
  import led_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PWM_W = PWM_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             wr,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);

  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             dir_dn_q, dir_dn_d;
  logic             blink_q, blink_d;

  logic [CNT_W-1:0] period_eff;
  logic             last;

  // A stored period of 0 behaves as 1.
  assign period_eff = (period_q == '0) ? CNT_W'(1) : period_q;
  assign last       = (cnt_q == period_eff - CNT_W'(1));

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    dir_dn_d = dir_dn_q;
    blink_d  = blink_q;
    if (wr) begin
      // A write always wins over a coincident tick.
      mode_d   = cfg_mode;
      period_d = cfg_period;
      cnt_d    = '0;
      duty_d   = '0;
      dir_dn_d = 1'b0;
      blink_d  = 1'b0;
    end else if (en && tick && (mode_q == MODE_BLINK || mode_q == MODE_BREATHE)) begin
      if (!last) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
        if (mode_q == MODE_BLINK) begin
          blink_d = ~blink_q;
        end else if (!dir_dn_q && duty_q == DUTY_MAX) begin
          dir_dn_d = 1'b1;
        end else if (dir_dn_q && duty_q == '0) begin
          dir_dn_d = 1'b0;
        end else if (dir_dn_q) begin
          duty_d = duty_q - PWM_W'(1);
        end else begin
          duty_d = duty_q + PWM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      period_q <= CNT_W'(1);
      cnt_q    <= '0;
      duty_q   <= '0;
      dir_dn_q <= 1'b0;
      blink_q  <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      dir_dn_q <= dir_dn_d;
      blink_q  <= blink_d;
    end
  end

  always_comb begin
    case (mode_q)
      MODE_ON:      led = 1'b1;
      MODE_BLINK:   led = blink_q;
      MODE_BREATHE: led = (pwm_cnt < duty_q);
      default:      led = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_ctrl_multi.sv
// Multi-channel LED controller: shared prescaler and PWM counter feeding NUM_CH channels,
// with registered LED and tick outputs.
module led_ctrl_multi
  import led_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned TICK_DIV = 10000,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PWM_W    = PWM_W_DEFAULT,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  output logic [NUM_CH-1:0] led_o,
  output logic              tick_o
);

  localparam int unsigned      PRE_W   = $clog2(TICK_DIV);
  localparam logic [PWM_W-1:0] PWM_TOP = PWM_W'((1 << PWM_W) - 2);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [PWM_W-1:0]  pwm_q, pwm_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic              tick_q;
  logic              tick;

  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] ch_led;

  assign tick = en && (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    pre_d = pre_q;
    pwm_d = pwm_q;
    led_d = led_q;
    if (en) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      pwm_d = (pwm_q == PWM_TOP) ? '0 : pwm_q + PWM_W'(1);
      led_d = ch_led;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      pwm_q  <= '0;
      led_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      pwm_q  <= pwm_d;
      led_q  <= led_d;
      tick_q <= tick;
    end
  end

  // Out-of-range channel indices match no channel and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_wr[i] = cfg_we && (cfg_ch == CH_W'(i));

    led_ch #(
      .CNT_W(CNT_W),
      .PWM_W(PWM_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .tick      (tick),
      .wr        (ch_wr[i]),
      .cfg_mode  (cfg_mode),
      .cfg_period(cfg_period),
      .pwm_cnt   (pwm_q),
      .led       (ch_led[i])
    );
  end

  assign led_o  = led_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Scoreboard bench for led_ctrl_multi: a 4-channel instance plus a 3-channel instance
// that sees the same stimulus, so index 3 is out of range for the second one.
module tb_led_ctrl_multi;
  import led_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, cfg_we;
  logic [1:0] cfg_ch, cfg_mode;
  logic [7:0] cfg_period;
  logic [3:0] led_o;
  logic       tick_o;
  logic [2:0] led3;
  logic       tick3;

  led_ctrl_multi #(.NUM_CH(4), .TICK_DIV(4), .CNT_W(8), .PWM_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .led_o(led_o), .tick_o(tick_o)
  );

  led_ctrl_multi #(.NUM_CH(3), .TICK_DIV(4), .CNT_W(8), .PWM_W(4)) dut3 (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .led_o(led3), .tick_o(tick3)
  );

  // Number of rising edges so far; expectations are keyed on it.
  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  localparam int KLed = 0, KTick = 1, KLed3 = 2, KTick3 = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic expect_at(input int c, input int k, input logic [3:0] v, input string n);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic exp_led(input int c, input logic [3:0] v, input logic [2:0] v3,
                         input string n);
    expect_at(c, KLed, v, n);
    expect_at(c, KLed3, {1'b0, v3}, {n, "_3ch"});
  endtask

  task automatic exp_tick(input int c, input logic v, input string n);
    expect_at(c, KTick, {3'b000, v}, n);
    expect_at(c, KTick3, {3'b000, v}, {n, "_3ch"});
  endtask

  // Monitor: outputs sampled on the falling edge after edge number `edges`.
  always @(negedge clk) begin
    logic [3:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edges) begin
        case (sb[i].kind)
          KLed:    act = led_o;
          KTick:   act = {3'b000, tick_o};
          KLed3:   act = {1'b0, led3};
          default: act = {3'b000, tick3};
        endcase
        total++;
        if (act !== sb[i].val) begin
          bad++;
          $display("FAIL %s at edge %0d: got %b expected %b", sb[i].name, edges, act,
                   sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic goto(input int k);
    while (edges < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe is sampled at edge at+1, so the channel config loads there.
  task automatic wr(input logic [1:0] ch, input logic [1:0] m, input logic [7:0] p,
                    input int at);
    goto(at);
    cfg_ch = ch; cfg_mode = m; cfg_period = p; cfg_we = 1'b1;
    goto(at + 1);
    cfg_we = 1'b0;
  endtask

  function automatic int duty_after(input int n);
    int m;
    m = n % 32;
    if (m <= 15) return m;
    if (m == 16) return 15;
    return 31 - m;
  endfunction

  // Breathe on ch1, period 1, loaded at edge 161: first tick edge 163, one step per tick.
  // PWM counter after edge x (x>100) is (x-23) mod 15 given the 20-edge pause.
  function automatic logic breathe_led(input int e);
    int x, pwm, tc;
    x   = e - 1;
    pwm = (x - 23) % 15;
    tc  = (x >= 163) ? (x - 163) / 4 + 1 : 0;
    return pwm < duty_after(tc);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_period = '0;

    // Reset held for edges 1..3; tick edges then fall at 7, 11, 15, ...
    for (int c = 1; c <= 20; c++) begin
      exp_led(c, 4'b0000, 3'b000, "reset_led");
      exp_tick(c, (c == 7 || c == 11 || c == 15 || c == 19), "reset_tick");
    end
    goto(3);
    rst = 1'b0;

    // ch2 ON then OFF
    exp_led(21, 4'b0000, 3'b000, "on_latency");
    exp_led(22, 4'b0100, 3'b100, "on_shown");
    exp_led(31, 4'b0100, 3'b100, "on_held");
    exp_led(32, 4'b0000, 3'b000, "off_shown");
    exp_tick(23, 1'b1, "tick_period");
    exp_tick(24, 1'b0, "tick_width");
    wr(2'd2, MODE_ON, 8'd1, 20);
    wr(2'd2, MODE_OFF, 8'd1, 30);

    // ch0 BLINK period 3, loaded at 41; toggles at tick edges 51, 63, 75
    exp_led(51, 4'b0000, 3'b000, "blink_dark");
    exp_led(52, 4'b0001, 3'b001, "blink_rise");
    exp_led(63, 4'b0001, 3'b001, "blink_hi");
    exp_led(64, 4'b0000, 3'b000, "blink_fall");
    exp_led(75, 4'b0000, 3'b000, "blink_dark2");
    exp_led(76, 4'b0001, 3'b001, "blink_rise2");
    exp_tick(79, 1'b1, "tick_before_pause");
    exp_tick(80, 1'b0, "tick_before_pause_low");
    // en=0 over edges 81..100; a ch2 ON write lands at 86 but led_o holds
    exp_led(81, 4'b0001, 3'b001, "pause_hold");
    exp_led(90, 4'b0001, 3'b001, "pause_hold_wr");
    exp_led(100, 4'b0001, 3'b001, "pause_hold_end");
    exp_tick(83, 1'b0, "pause_no_tick");
    exp_tick(99, 1'b0, "pause_no_tick2");
    exp_tick(101, 1'b0, "resume_tick_phase");
    exp_tick(103, 1'b1, "resume_tick");
    exp_tick(104, 1'b0, "resume_tick_low");
    exp_led(101, 4'b0101, 3'b101, "resume_wr_seen");
    exp_led(105, 4'b0101, 3'b101, "ch2_off_latency");
    exp_led(106, 4'b0001, 3'b001, "ch2_off");
    exp_led(107, 4'b0001, 3'b001, "blink_resume_hi");
    exp_led(108, 4'b0000, 3'b000, "blink_resume_fall");
    exp_led(119, 4'b0000, 3'b000, "blink_resume_dark");
    exp_led(120, 4'b0001, 3'b001, "blink_resume_rise");
    exp_led(122, 4'b0001, 3'b001, "ch0_off_latency");
    exp_led(123, 4'b0000, 3'b000, "ch0_off");
    wr(2'd0, MODE_BLINK, 8'd3, 40);
    goto(80);
    en = 1'b0;
    wr(2'd2, MODE_ON, 8'd1, 85);
    goto(100);
    en = 1'b1;
    wr(2'd2, MODE_OFF, 8'd1, 104);
    wr(2'd0, MODE_OFF, 8'd1, 121);

    // ch3 BLINK period 2 written on tick edge 131: write wins, cnt starts at 0
    exp_led(139, 4'b0000, 3'b000, "tick_wr_dark");
    exp_led(140, 4'b1000, 3'b000, "tick_wr_rise");
    exp_led(147, 4'b1000, 3'b000, "tick_wr_hi");
    exp_led(148, 4'b0000, 3'b000, "tick_wr_fall");
    wr(2'd3, MODE_BLINK, 8'd2, 130);
    wr(2'd3, MODE_OFF, 8'd1, 150);

    // ch1 BREATHE period 1 from 161; ch3 ON at 201 is out of range for the 3-channel copy
    for (int e = 162; e <= 300; e++) begin
      logic b;
      b = breathe_led(e);
      exp_led(e, {(e >= 202), 1'b0, b, 1'b0}, {1'b0, b, 1'b0}, "breathe");
    end
    wr(2'd1, MODE_BREATHE, 8'd1, 160);
    wr(2'd3, MODE_ON, 8'd5, 200);

    // Single-cycle reset at edge 301 mid-breathe; config is gone afterwards
    for (int c = 301; c <= 330; c++) begin
      exp_led(c, 4'b0000, 3'b000, "rst_mid_led");
    end
    exp_tick(301, 1'b0, "rst_mid_tick");
    exp_tick(304, 1'b0, "rst_mid_tick_phase");
    exp_tick(305, 1'b1, "rst_mid_tick_first");
    exp_tick(309, 1'b1, "rst_mid_tick_next");
    goto(300);
    rst = 1'b1;
    goto(301);
    rst = 1'b0;

    goto(335);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
